// File: rtl/sw_evt_id_fifo.sv
// Per-core software-event consumer: captures event pulses into a pending vector, serialises them
// lowest index first into an ID FIFO, and exposes pop/mask/pending/status over a slave port.
module sw_evt_id_fifo #(
  parameter int unsigned NB_SW_EVT  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned EVT_ID_W  = $clog2(NB_SW_EVT),
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NB_SW_EVT-1:0] sw_events_i,
  output logic                 evt_valid_o,
  input  logic                 req_i,
  input  logic                 we_n_i,
  input  logic [3:0]           add_i,
  input  logic [31:0]          wdata_i,
  output logic                 gnt_o,
  output logic                 r_valid_o,
  output logic [31:0]          r_rdata_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] RegPop     = 2'd0;
  localparam logic [1:0] RegMask    = 2'd1;
  localparam logic [1:0] RegPending = 2'd2;
  localparam logic [1:0] RegStatus  = 2'd3;

  logic [NB_SW_EVT-1:0] pending_q, pending_d;
  logic [NB_SW_EVT-1:0] mask_q, mask_d;
  logic                 ovf_q, ovf_d;
  logic [EVT_ID_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 r_valid_q;
  logic [31:0]          r_rdata_q, rdata_d;

  logic [1:0]           reg_sel;
  logic                 rd, wr, pop, push, full, ovf_set, ovf_clr;
  logic [NB_SW_EVT-1:0] arrivals, drain_oh, pend_clr;
  logic [EVT_ID_W-1:0]  drain_id;

  assign reg_sel = add_i[3:2];
  assign rd      = req_i & we_n_i;
  assign wr      = req_i & ~we_n_i;
  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign pop     = rd && (reg_sel == RegPop) && (cnt_q != '0);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept a drain.
  assign push    = (|pending_q) && (!full || pop);

  assign arrivals = sw_events_i & mask_q;
  assign drain_oh = push ? (pending_q & (~pending_q + NB_SW_EVT'(1))) : '0;
  assign pend_clr = (wr && (reg_sel == RegPending)) ? wdata_i[NB_SW_EVT-1:0] : '0;
  assign ovf_set  = |(arrivals & pending_q & ~drain_oh);
  assign ovf_clr  = wr && (reg_sel == RegStatus) && wdata_i[0];

  always_comb begin
    drain_id = '0;
    for (int i = int'(NB_SW_EVT) - 1; i >= 0; i--) begin
      if (pending_q[i]) drain_id = EVT_ID_W'(i);
    end
  end

  always_comb begin
    pending_d = (pending_q & ~drain_oh & ~pend_clr) | arrivals;
    ovf_d     = ovf_set | (ovf_q & ~ovf_clr);
    mask_d    = (wr && (reg_sel == RegMask)) ? wdata_i[NB_SW_EVT-1:0] : mask_q;
    cnt_d     = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      unique case (reg_sel)
        RegPop: begin
          if (cnt_q != '0) begin
            rdata_d[31]           = 1'b1;
            rdata_d[30]           = ovf_q;
            rdata_d[EVT_ID_W-1:0] = mem_q[rptr_q];
          end
        end
        RegMask:    rdata_d[NB_SW_EVT-1:0] = mask_q;
        RegPending: rdata_d[NB_SW_EVT-1:0] = pending_q;
        RegStatus: begin
          rdata_d[31]        = ovf_q;
          rdata_d[CNT_W-1:0] = cnt_q;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      mask_q    <= '1;
      ovf_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      r_valid_q <= 1'b0;
      r_rdata_q <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      r_valid_q <= req_i;
      r_rdata_q <= rdata_d;
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: entries are only read while the count says they are live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= drain_id;
  end

  assign evt_valid_o = (cnt_q != '0);
  assign gnt_o       = req_i;
  assign r_valid_o   = r_valid_q;
  assign r_rdata_o   = r_rdata_q;

endmodule

// File: tb/tb_sw_evt_id_fifo.sv
// Scoreboard bench for sw_evt_id_fifo: bus responses are queued as they are issued and checked
// by an independent monitor whenever r_valid_o is seen.
module tb_sw_evt_id_fifo;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  sw_events_i = '0;
  logic        evt_valid_o;
  logic        req_i = 1'b0;
  logic        we_n_i = 1'b1;
  logic [3:0]  add_i = '0;
  logic [31:0] wdata_i = '0;
  logic        gnt_o;
  logic        r_valid_o;
  logic [31:0] r_rdata_o;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  sw_evt_id_fifo #(
    .NB_SW_EVT (8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .sw_events_i(sw_events_i),
    .evt_valid_o(evt_valid_o),
    .req_i      (req_i),
    .we_n_i     (we_n_i),
    .add_i      (add_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .r_valid_o  (r_valid_o),
    .r_rdata_o  (r_rdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (r_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got %h, expected no response", r_rdata_o);
      end else begin
        e = exp_q.pop_front();
        check(e.name, r_rdata_o, e.val);
      end
    end
  end

  // Issues one bus cycle; call right after posedge+1, returns at the next posedge+1.
  task automatic bus(input logic we_n, input logic [1:0] sel, input logic [31:0] wd,
                     input logic [31:0] exp, input string name);
    req_i   = 1'b1;
    we_n_i  = we_n;
    add_i   = {sel, 2'b00};
    wdata_i = wd;
    exp_q.push_back('{name, exp});
    #1 check("gnt", {31'd0, gnt_o}, 32'd1);
    @(posedge clk_i);
    #1;
    req_i   = 1'b0;
    we_n_i  = 1'b1;
    add_i   = '0;
    wdata_i = '0;
  endtask

  task automatic rd(input logic [1:0] sel, input logic [31:0] exp, input string name);
    bus(1'b1, sel, 32'd0, exp, name);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] wd, input string name);
    bus(1'b0, sel, wd, 32'd0, name);
  endtask

  task automatic pulse(input logic [7:0] ev);
    sw_events_i = ev;
    @(posedge clk_i);
    #1;
    sw_events_i = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle(2);
    check("rst_evt_valid", {31'd0, evt_valid_o}, 32'd0);
    check("rst_r_valid", {31'd0, r_valid_o}, 32'd0);
    check("rst_r_rdata", r_rdata_o, 32'd0);
    rst_ni = 1'b1;
    idle(1);

    // Single event: latency and pop.
    pulse(8'h20);
    check("evt_valid_n1", {31'd0, evt_valid_o}, 32'd0);
    idle(1);
    check("evt_valid_n2", {31'd0, evt_valid_o}, 32'd1);
    rd(2'd0, 32'h8000_0005, "pop_id5");
    rd(2'd0, 32'h0000_0000, "pop_empty");
    check("evt_valid_empty", {31'd0, evt_valid_o}, 32'd0);

    // Multi-hot burst drains lowest index first.
    pulse(8'b1001_0110);
    idle(5);
    rd(2'd0, 32'h8000_0001, "burst_id1");
    rd(2'd0, 32'h8000_0002, "burst_id2");
    rd(2'd0, 32'h8000_0004, "burst_id4");
    rd(2'd0, 32'h8000_0007, "burst_id7");
    rd(2'd3, 32'h0000_0000, "burst_status");

    // Full FIFO: pop and push in the same cycle.
    pulse(8'hFF);
    idle(6);
    rd(2'd3, 32'h0000_0004, "full_count");
    rd(2'd2, 32'h0000_00F0, "full_pending");
    rd(2'd0, 32'h8000_0000, "full_pop_id0");
    rd(2'd3, 32'h0000_0004, "full_count_after_pop");
    rd(2'd2, 32'h0000_00E0, "full_pending_after_pop");

    // Overflow on a repeated pending event while full.
    pulse(8'h08);
    pulse(8'h08);
    rd(2'd3, 32'h8000_0004, "ovf_status");
    rd(2'd0, 32'hC000_0001, "ovf_pop_id1");
    wr(2'd3, 32'h0000_0001, "ovf_clr_wr");
    rd(2'd3, 32'h0000_0004, "ovf_cleared");
    rd(2'd0, 32'h8000_0002, "drain_id2");
    rd(2'd0, 32'h8000_0003, "drain_id3a");
    rd(2'd0, 32'h8000_0004, "drain_id4");
    rd(2'd0, 32'h8000_0003, "drain_id3b");
    rd(2'd0, 32'h8000_0005, "drain_id5");
    rd(2'd0, 32'h8000_0006, "drain_id6");
    rd(2'd0, 32'h8000_0007, "drain_id7");
    check("drain_evt_valid", {31'd0, evt_valid_o}, 32'd0);

    // Mask and W1C.
    wr(2'd1, 32'h0000_00FE, "mask_wr_fe");
    pulse(8'h01);
    idle(2);
    rd(2'd2, 32'h0000_0000, "masked_pending");
    check("masked_evt_valid", {31'd0, evt_valid_o}, 32'd0);
    wr(2'd1, 32'h0000_00FF, "mask_wr_ff");
    rd(2'd1, 32'h0000_00FF, "mask_rd_ff");
    pulse(8'h0F);
    idle(5);
    pulse(8'h01);
    wr(2'd1, 32'h0000_00FE, "mask_wr_fe2");
    pulse(8'h01);
    rd(2'd2, 32'h0000_0001, "pending_kept");
    rd(2'd3, 32'h0000_0004, "no_ovf_masked");
    wr(2'd2, 32'h0000_0001, "w1c_wr");
    rd(2'd2, 32'h0000_0000, "w1c_cleared");

    // Reset with 3 IDs queued and a read in flight.
    rd(2'd0, 32'h8000_0000, "pre_rst_pop");
    req_i  = 1'b1;
    we_n_i = 1'b1;
    add_i  = 4'hC;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    req_i  = 1'b0;
    add_i  = '0;
    #1;
    check("mid_rst_evt_valid", {31'd0, evt_valid_o}, 32'd0);
    check("mid_rst_r_valid", {31'd0, r_valid_o}, 32'd0);
    check("mid_rst_r_rdata", r_rdata_o, 32'd0);
    idle(1);
    rst_ni = 1'b1;
    idle(1);
    rd(2'd1, 32'h0000_00FF, "post_rst_mask");
    rd(2'd3, 32'h0000_0000, "post_rst_status");
    check("post_rst_evt_valid", {31'd0, evt_valid_o}, 32'd0);

    idle(2);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
